vram_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between two requesters: a read-only video fetch port (VID) and a read/write CPU port (CPU).
- The RAM has 1-cycle registered read latency, samples cs/we/addr/data_in on posedge, and leaves data_out unchanged on writes.
- VID has fixed priority; a wait counter bounds CPU starvation. The block issues at most one RAM access per cycle and returns data through a per-port req/ack handshake.

---
 rtl/vram_arbiter.sv | 144 ++++++++++++++
 tb/tb_vram_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous RAM between a
// fixed-priority video read port and a starvation-bounded CPU port.
module vram_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_WAIT   = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  vid_req,
   input  logic [ADDR_WIDTH-1:0] vid_addr,
   output logic                  vid_ack,
   output logic [DATA_WIDTH-1:0] vid_rdata,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_ack,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   // Wide enough for the largest allowed MAX_WAIT (15).
   localparam int WW = 4;
   localparam logic [WW-1:0] MAX_W = WW'(MAX_WAIT);

   // Pipeline tag layout: [2]=valid, [1]=port (1=CPU), [0]=write.
   logic [2:0] s1_q, s1_d;
   logic [2:0] s2_q, s2_d;

   logic [WW-1:0]         wait_q, wait_d;
   logic                  vbusy_q, vbusy_d;
   logic                  cbusy_q, cbusy_d;
   logic                  vack_q, vack_d;
   logic                  cack_q, cack_d;
   logic [DATA_WIDTH-1:0] vrd_q, vrd_d;
   logic [DATA_WIDTH-1:0] crd_q, crd_d;
   logic                  cs_q, cs_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic vid_elig, cpu_elig;
   logic gnt_vid, gnt_cpu;

   // Eligibility and grant: VID first unless the CPU has waited MAX_WAIT.
   always_comb begin
      vid_elig = vid_req & ~vbusy_q & ~vack_q;
      cpu_elig = cpu_req & ~cbusy_q & ~cack_q;
      gnt_cpu  = cpu_elig & (~vid_elig | (wait_q == MAX_W));
      gnt_vid  = vid_elig & ~gnt_cpu;
   end

   // Next-state for issue, wait counter, pipeline tags, acks and data.
   always_comb begin
      wait_d = wait_q;
      if (gnt_cpu) begin
         wait_d = '0;
      end else if (gnt_vid && cpu_elig && (wait_q != MAX_W)) begin
         wait_d = wait_q + WW'(1);
      end

      cs_d    = gnt_vid | gnt_cpu;
      we_d    = gnt_cpu & cpu_we;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (gnt_cpu) begin
         addr_d  = cpu_addr;
         wdata_d = cpu_wdata;
      end else if (gnt_vid) begin
         addr_d  = vid_addr;
      end

      s1_d = {cs_d, gnt_cpu, we_d};
      s2_d = s1_q;

      vack_d = s2_q[2] & ~s2_q[1];
      cack_d = s2_q[2] & s2_q[1];

      vrd_d = vack_d ? ram_rdata : vrd_q;
      crd_d = (cack_d & ~s2_q[0]) ? ram_rdata : crd_q;

      vbusy_d = vbusy_q;
      if (gnt_vid) begin
         vbusy_d = 1'b1;
      end else if (vack_d) begin
         vbusy_d = 1'b0;
      end

      cbusy_d = cbusy_q;
      if (gnt_cpu) begin
         cbusy_d = 1'b1;
      end else if (cack_d) begin
         cbusy_d = 1'b0;
      end
   end

   // State registers; reset drops any in-flight access silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= '0;
         s2_q    <= '0;
         wait_q  <= '0;
         vbusy_q <= 1'b0;
         cbusy_q <= 1'b0;
         vack_q  <= 1'b0;
         cack_q  <= 1'b0;
         vrd_q   <= '0;
         crd_q   <= '0;
         cs_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         wait_q  <= wait_d;
         vbusy_q <= vbusy_d;
         cbusy_q <= cbusy_d;
         vack_q  <= vack_d;
         cack_q  <= cack_d;
         vrd_q   <= vrd_d;
         crd_q   <= crd_d;
         cs_q    <= cs_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign vid_ack   = vack_q;
   assign vid_rdata = vrd_q;
   assign cpu_ack   = cack_q;
   assign cpu_rdata = crd_q;
   assign ram_cs    = cs_q;
   assign ram_we    = we_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed cycle table plus hand-written sequences
// for starvation bound and asynchronous reset, against a RAM model.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vid_req;
   logic [15:0] vid_addr;
   logic        vid_ack;
   logic [7:0]  vid_rdata;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic        ram_cs;
   logic        ram_we;
   logic [15:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata = 8'h00;

   logic [7:0]  mem [0:65535];

   int n_chk  = 0;
   int n_fail = 0;

   vram_arbiter #(
      .ADDR_WIDTH(16),
      .DATA_WIDTH(8),
      .MAX_WAIT(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .vid_req(vid_req),
      .vid_addr(vid_addr),
      .vid_ack(vid_ack),
      .vid_rdata(vid_rdata),
      .cpu_req(cpu_req),
      .cpu_we(cpu_we),
      .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack),
      .cpu_rdata(cpu_rdata),
      .ram_cs(ram_cs),
      .ram_we(ram_we),
      .ram_addr(ram_addr),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr];
      end
   end

   typedef struct {
      logic        vr;
      logic [15:0] va;
      logic        cr;
      logic        cw;
      logic [15:0] ca;
      logic [7:0]  cd;
      logic        e_cs;
      logic        e_we;
      logic [15:0] e_ra;
      logic [7:0]  e_rw;
      logic        e_vack;
      logic [7:0]  e_vd;
      logic        e_cack;
      logic [7:0]  e_cd;
   } vec_t;

   vec_t vecs [25];

   function automatic vec_t mk(
      input logic vr, input logic [15:0] va,
      input logic cr, input logic cw,
      input logic [15:0] ca, input logic [7:0] cd,
      input logic ecs, input logic ewe,
      input logic [15:0] era, input logic [7:0] erw,
      input logic evk, input logic [7:0] evd,
      input logic eck, input logic [7:0] ecd);
      vec_t v;
      v.vr = vr; v.va = va; v.cr = cr; v.cw = cw;
      v.ca = ca; v.cd = cd;
      v.e_cs = ecs; v.e_we = ewe; v.e_ra = era; v.e_rw = erw;
      v.e_vack = evk; v.e_vd = evd; v.e_cack = eck; v.e_cd = ecd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " ram_cs"}, 32'(ram_cs), 0);
      chk({tag, " ram_we"}, 32'(ram_we), 0);
      chk({tag, " ram_addr"}, 32'(ram_addr), 0);
      chk({tag, " ram_wdata"}, 32'(ram_wdata), 0);
      chk({tag, " vid_ack"}, 32'(vid_ack), 0);
      chk({tag, " vid_rdata"}, 32'(vid_rdata), 0);
      chk({tag, " cpu_ack"}, 32'(cpu_ack), 0);
      chk({tag, " cpu_rdata"}, 32'(cpu_rdata), 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      mem[16'h1234] = 8'hA5;
      mem[16'h8000] = 8'h11;
      mem[16'h8001] = 8'h22;
      mem[16'h0001] = 8'h33;
      mem[16'h0020] = 8'h77;

      //            vr va       cr cw ca       cd     cs we ra       rw     vk vd     ck cd
      vecs[0]  = mk(0, 16'h0000, 1, 0, 16'h1234, 8'h00, 1, 0, 16'h1234, 8'h00, 0, 8'h00, 0, 8'h00);
      vecs[1]  = mk(0, 16'h0000, 1, 0, 16'h1234, 8'h00, 0, 0, 16'h1234, 8'h00, 0, 8'h00, 0, 8'h00);
      vecs[2]  = mk(0, 16'h0000, 1, 0, 16'h1234, 8'h00, 0, 0, 16'h1234, 8'h00, 0, 8'h00, 1, 8'hA5);
      vecs[3]  = mk(0, 16'h0000, 0, 0, 16'h1234, 8'h00, 0, 0, 16'h1234, 8'h00, 0, 8'h00, 0, 8'hA5);
      vecs[4]  = mk(0, 16'h0000, 1, 1, 16'h0010, 8'h5A, 1, 1, 16'h0010, 8'h5A, 0, 8'h00, 0, 8'hA5);
      vecs[5]  = mk(0, 16'h0000, 1, 1, 16'h0010, 8'h5A, 0, 0, 16'h0010, 8'h5A, 0, 8'h00, 0, 8'hA5);
      vecs[6]  = mk(0, 16'h0000, 1, 1, 16'h0010, 8'h5A, 0, 0, 16'h0010, 8'h5A, 0, 8'h00, 1, 8'hA5);
      vecs[7]  = mk(0, 16'h0000, 1, 0, 16'h0010, 8'h00, 0, 0, 16'h0010, 8'h5A, 0, 8'h00, 0, 8'hA5);
      vecs[8]  = mk(0, 16'h0000, 1, 0, 16'h0010, 8'h00, 1, 0, 16'h0010, 8'h00, 0, 8'h00, 0, 8'hA5);
      vecs[9]  = mk(0, 16'h0000, 1, 0, 16'h0010, 8'h00, 0, 0, 16'h0010, 8'h00, 0, 8'h00, 0, 8'hA5);
      vecs[10] = mk(0, 16'h0000, 1, 0, 16'h0010, 8'h00, 0, 0, 16'h0010, 8'h00, 0, 8'h00, 1, 8'h5A);
      vecs[11] = mk(0, 16'h0000, 0, 0, 16'h0010, 8'h00, 0, 0, 16'h0010, 8'h00, 0, 8'h00, 0, 8'h5A);
      vecs[12] = mk(1, 16'h8000, 1, 0, 16'h0001, 8'h00, 1, 0, 16'h8000, 8'h00, 0, 8'h00, 0, 8'h5A);
      vecs[13] = mk(1, 16'h8000, 1, 0, 16'h0001, 8'h00, 1, 0, 16'h0001, 8'h00, 0, 8'h00, 0, 8'h5A);
      vecs[14] = mk(1, 16'h8000, 1, 0, 16'h0001, 8'h00, 0, 0, 16'h0001, 8'h00, 1, 8'h11, 0, 8'h5A);
      vecs[15] = mk(1, 16'h8001, 1, 0, 16'h0001, 8'h00, 0, 0, 16'h0001, 8'h00, 0, 8'h11, 1, 8'h33);
      vecs[16] = mk(1, 16'h8001, 0, 0, 16'h0001, 8'h00, 1, 0, 16'h8001, 8'h00, 0, 8'h11, 0, 8'h33);
      vecs[17] = mk(1, 16'h8001, 0, 0, 16'h0001, 8'h00, 0, 0, 16'h8001, 8'h00, 0, 8'h11, 0, 8'h33);
      vecs[18] = mk(1, 16'h8001, 0, 0, 16'h0001, 8'h00, 0, 0, 16'h8001, 8'h00, 1, 8'h22, 0, 8'h33);
      vecs[19] = mk(0, 16'h8001, 0, 0, 16'h0001, 8'h00, 0, 0, 16'h8001, 8'h00, 0, 8'h22, 0, 8'h33);
      vecs[20] = mk(1, 16'h0020, 0, 0, 16'h0001, 8'h00, 1, 0, 16'h0020, 8'h00, 0, 8'h22, 0, 8'h33);
      vecs[21] = mk(1, 16'h0020, 1, 1, 16'h0020, 8'h99, 1, 1, 16'h0020, 8'h99, 0, 8'h22, 0, 8'h33);
      vecs[22] = mk(1, 16'h0020, 1, 1, 16'h0020, 8'h99, 0, 0, 16'h0020, 8'h99, 1, 8'h77, 0, 8'h33);
      vecs[23] = mk(0, 16'h0020, 1, 1, 16'h0020, 8'h99, 0, 0, 16'h0020, 8'h99, 0, 8'h77, 1, 8'h33);
      vecs[24] = mk(0, 16'h0020, 0, 0, 16'h0020, 8'h00, 0, 0, 16'h0020, 8'h99, 0, 8'h77, 0, 8'h33);

      rst_n = 1'b0;
      vid_req = 0; vid_addr = '0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      #2;
      chk_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 25; i++) begin
         vid_req = vecs[i].vr; vid_addr = vecs[i].va;
         cpu_req = vecs[i].cr; cpu_we = vecs[i].cw;
         cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cd;
         tick();
         chk($sformatf("row%0d ram_cs", i), 32'(ram_cs), 32'(vecs[i].e_cs));
         chk($sformatf("row%0d ram_we", i), 32'(ram_we), 32'(vecs[i].e_we));
         chk($sformatf("row%0d ram_addr", i), 32'(ram_addr), 32'(vecs[i].e_ra));
         chk($sformatf("row%0d ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].e_rw));
         chk($sformatf("row%0d vid_ack", i), 32'(vid_ack), 32'(vecs[i].e_vack));
         chk($sformatf("row%0d vid_rdata", i), 32'(vid_rdata), 32'(vecs[i].e_vd));
         chk($sformatf("row%0d cpu_ack", i), 32'(cpu_ack), 32'(vecs[i].e_cack));
         chk($sformatf("row%0d cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].e_cd));
      end

      // Starvation bound: CPU loses to VID at 0,4,8 then is forced at 12.
      for (int k = 0; k < 16; k++) begin
         vid_req  = (k <= 13);
         vid_addr = 16'h8000;
         cpu_req  = (k == 0) || (k == 4) || (k == 8) || (k >= 12 && k <= 14);
         cpu_we   = 1'b0;
         cpu_addr = 16'h1234;
         cpu_wdata = 8'h00;
         tick();
         if (k == 0 || k == 4 || k == 8 || k == 13) begin
            chk($sformatf("starve k%0d cs", k), 32'(ram_cs), 1);
            chk($sformatf("starve k%0d vid addr", k), 32'(ram_addr), 32'h8000);
         end
         if (k == 12) begin
            chk("starve forced cs", 32'(ram_cs), 1);
            chk("starve forced cpu addr", 32'(ram_addr), 32'h1234);
         end
         if (k == 14) begin
            chk("starve cpu_ack", 32'(cpu_ack), 1);
            chk("starve cpu_rdata", 32'(cpu_rdata), 32'hA5);
         end
         if (k == 15) begin
            chk("starve vid_ack after drop", 32'(vid_ack), 1);
            chk("starve vid_rdata", 32'(vid_rdata), 32'h11);
         end
      end
      cpu_req = 0; vid_req = 0;
      repeat (3) tick();

      // Asynchronous reset right after a VID grant.
      vid_req = 1; vid_addr = 16'h8001;
      tick();
      chk("rst grant cs", 32'(ram_cs), 1);
      chk("rst grant addr", 32'(ram_addr), 32'h8001);
      #3 rst_n = 1'b0;
      vid_req = 0;
      #1;
      chk_all_zero("async rst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("no ack after rst c%0d", c), 32'(vid_ack), 0);
         chk($sformatf("no cs after rst c%0d", c), 32'(ram_cs), 0);
      end
      vid_req = 1; vid_addr = 16'h8001;
      tick();
      chk("post rst grant", 32'(ram_cs), 1);
      tick();
      chk("post rst no early ack", 32'(vid_ack), 0);
      tick();
      chk("post rst vid_ack", 32'(vid_ack), 1);
      chk("post rst vid_rdata", 32'(vid_rdata), 32'h22);
      vid_req = 0;
      tick();
      chk("post rst ack drop", 32'(vid_ack), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
